// File: rtl/lcd_16x2_ctrl_pkg.sv
// Shared definitions for the HD44780-style 16x2 LCD controller.
// Holds the state encoding, the init command table and the fixed display codes.
package lcd_16x2_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_CLR_WAIT,
    ST_IDLE,
    ST_LINE_ISSUE,
    ST_LINE_WAIT,
    ST_CHAR_ISSUE,
    ST_CHAR_WAIT
  } state_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;

  localparam logic [1:0] CLR_IDX       = 2'd2;
  localparam logic [1:0] LAST_INIT_IDX = 2'd3;

  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  localparam int unsigned BUF_DEPTH = 32;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_CLEAR;
      default: cmd = CMD_ENTRY;
    endcase
    return cmd;
  endfunction

  // Width able to hold 0 .. max(a,b)-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lcd_16x2_ctrl_char_buf.sv
// 32x8 character buffer: synchronous write, asynchronous read, resets to spaces.
// A write and a read of the same index in one cycle return the old contents.
module lcd_char_buf
  import lcd_16x2_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [BUF_DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= SPACE_CHAR;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_16x2_ctrl.sv
// Sequencer for a 16x2 character LCD: power-up delay, init commands, and full
// screen refreshes from a 32-entry buffer, one byte at a time via a byte driver.
//
// state      | meaning
// PWRUP      | wait PWRUP_CYCLES after reset
// INIT_ISSUE | launch init command init_idx
// INIT_WAIT  | wait driver done for an init command
// CLR_WAIT   | extra CLR_CYCLES delay after clear-display
// IDLE       | nothing to do, accepts refresh
// LINE_ISSUE | launch set-DDRAM-address for line 1 or 2
// LINE_WAIT  | wait driver done for the line address
// CHAR_ISSUE | launch buffer character char_idx
// CHAR_WAIT  | wait driver done for that character
module lcd_16x2_ctrl
  import lcd_16x2_ctrl_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES = 750000,
  parameter int unsigned CLR_CYCLES   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  output logic [7:0] drv_data,
  output logic       drv_cd,
  output logic       drv_start,
  input  logic       drv_done,
  output logic       init_done,
  output logic       busy
);

  localparam int unsigned CNT_W = cnt_width(PWRUP_CYCLES, CLR_CYCLES);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'((PWRUP_CYCLES == 0) ? 0 : PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'((CLR_CYCLES == 0) ? 0 : CLR_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       init_idx_q, init_idx_d;
  logic [4:0]       char_idx_q, char_idx_d;
  logic             pending_q, pending_d;
  logic             init_done_q, init_done_d;
  logic [7:0]       drv_data_q;
  logic             drv_cd_q;
  logic             drv_start_q;

  logic             issue;
  logic [7:0]       issue_data;
  logic             issue_cd;
  logic             start_seq;
  logic [7:0]       rd_data;

  lcd_char_buf u_char_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (char_idx_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    char_idx_d  = char_idx_q;
    pending_d   = pending_q;
    init_done_d = init_done_q;
    issue       = 1'b0;
    issue_data  = drv_data_q;
    issue_cd    = drv_cd_q;
    start_seq   = 1'b0;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d    = ST_INIT_ISSUE;
          cnt_d      = '0;
          init_idx_d = 2'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_INIT_ISSUE: begin
        issue      = 1'b1;
        issue_data = init_cmd(init_idx_q);
        issue_cd   = 1'b0;
        state_d    = ST_INIT_WAIT;
      end

      ST_INIT_WAIT: begin
        if (drv_done) begin
          if (init_idx_q == LAST_INIT_IDX) begin
            init_done_d = 1'b1;
            start_seq   = 1'b1;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            if (init_idx_q == CLR_IDX && CLR_CYCLES != 0) begin
              state_d = ST_CLR_WAIT;
              cnt_d   = '0;
            end else begin
              state_d = ST_INIT_ISSUE;
            end
          end
        end
      end

      ST_CLR_WAIT: begin
        if (cnt_q == CLR_LAST) begin
          state_d = ST_INIT_ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_IDLE: begin
        if (refresh) begin
          start_seq = 1'b1;
        end
      end

      ST_LINE_ISSUE: begin
        issue      = 1'b1;
        issue_data = char_idx_q[4] ? LINE2_ADDR : LINE1_ADDR;
        issue_cd   = 1'b0;
        state_d    = ST_LINE_WAIT;
      end

      ST_LINE_WAIT: begin
        if (drv_done) begin
          state_d = ST_CHAR_ISSUE;
        end
      end

      ST_CHAR_ISSUE: begin
        issue      = 1'b1;
        issue_data = rd_data;
        issue_cd   = 1'b1;
        state_d    = ST_CHAR_WAIT;
      end

      ST_CHAR_WAIT: begin
        if (drv_done) begin
          if (char_idx_q == 5'd31) begin
            char_idx_d = 5'd0;
            if (pending_q) begin
              start_seq = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            char_idx_d = char_idx_q + 5'd1;
            state_d    = (char_idx_q == 5'd15) ? ST_LINE_ISSUE : ST_CHAR_ISSUE;
          end
        end
      end

      default: begin
        state_d = ST_PWRUP;
      end
    endcase

    // A refresh that starts now covers any request seen up to this cycle.
    if (start_seq) begin
      state_d    = ST_LINE_ISSUE;
      char_idx_d = 5'd0;
      pending_d  = 1'b0;
    end else if (refresh && state_q != ST_IDLE) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= '0;
      init_idx_q  <= 2'd0;
      char_idx_q  <= 5'd0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      drv_data_q  <= 8'h00;
      drv_cd_q    <= 1'b0;
      drv_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      char_idx_q  <= char_idx_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      drv_start_q <= issue;
      if (issue) begin
        drv_data_q <= issue_data;
        drv_cd_q   <= issue_cd;
      end
    end
  end

  assign drv_data  = drv_data_q;
  assign drv_cd    = drv_cd_q;
  assign drv_start = drv_start_q;
  assign init_done = init_done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_16x2_ctrl.sv
// Bench for lcd_16x2_ctrl: transfer-level model of the expected byte stream,
// a byte-driver model answering done 3 cycles after start, and directed scenarios.
module tb_lcd_16x2_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       refresh;
  logic [7:0] drv_data;
  logic       drv_cd;
  logic       drv_start;
  logic       drv_done;
  logic       init_done;
  logic       busy;

  lcd_16x2_ctrl #(
    .PWRUP_CYCLES (10),
    .CLR_CYCLES   (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .refresh   (refresh),
    .drv_data  (drv_data),
    .drv_cd    (drv_cd),
    .drv_start (drv_start),
    .drv_done  (drv_done),
    .init_done (init_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;

  logic [8:0] exp_q[$];
  logic [8:0] log_q[$];
  int         start_cyc_q[$];
  logic [7:0] mbuf [32];
  bit         outstanding = 0;
  bit         mpending = 0;
  logic [8:0] cur;
  int         init_seen = 0;
  int         cyc = 0;
  int         chars_in_seq = 0;
  bit         hold = 0;
  int         spur_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_push_refresh();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, mbuf[i]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, mbuf[i]});
  endtask

  task automatic model_reset();
    exp_q.delete();
    outstanding = 0;
    mpending    = 0;
    init_seen   = 0;
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    model_push_refresh();
  endtask

  // Byte-driver model: done pulses 3 cycles after start unless held.
  initial begin
    int dly;
    int spur_seen;
    dly       = 0;
    spur_seen = 0;
    drv_done  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      drv_done = 1'b0;
      if (rst !== 1'b1) begin
        dly = 0;
      end else if (drv_start) begin
        dly = 2;
      end else if (dly > 0 && !hold) begin
        dly--;
        if (dly == 0) drv_done = 1'b1;
      end
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        drv_done  = 1'b1;
      end
    end
  end

  // Compare process: every transfer against the model, plus per-cycle invariants.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst === 1'b1) begin
        if (drv_start) begin
          check("start_before_done", 32'(outstanding), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_start", 32'({drv_cd, drv_data}), 32'h1FF);
          end else begin
            e = exp_q.pop_front();
            check("xfer", 32'({drv_cd, drv_data}), 32'(e));
          end
          check("init_done_at_start", 32'(init_done), 32'(init_seen >= 4));
          if (init_seen < 4) init_seen++;
          log_q.push_back({drv_cd, drv_data});
          start_cyc_q.push_back(cyc);
          if (drv_cd) chars_in_seq++;
          outstanding = 1;
          cur = {drv_cd, drv_data};
        end else if (outstanding) begin
          check("hold_stable", 32'({drv_cd, drv_data}), 32'(cur));
        end
        if (outstanding || exp_q.size() != 0) check("busy_active", 32'(busy), 32'd1);
        if (drv_done && outstanding && !drv_start) begin
          outstanding = 0;
          if (exp_q.size() == 0 && mpending) begin
            model_push_refresh();
            mpending = 0;
          end
        end
      end
    end
  end

  // Callers are positioned just after a negedge.
  task automatic write_char(input logic [4:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    mbuf[a] = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    if (exp_q.size() == 0 && !outstanding) model_push_refresh();
    else mpending = 1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!(busy === 1'b0 && exp_q.size() == 0 && !outstanding) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
    check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    refresh = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    check("rst_start", 32'(drv_start), 32'd0);
    check("rst_cd",    32'(drv_cd),    32'd0);
    check("rst_data",  32'(drv_data),  32'h00);
    check("rst_init",  32'(init_done), 32'd0);
    check("rst_busy",  32'(busy),      32'd1);

    // Power-up: first start 11 cycles after release, then init + auto refresh
    log_q.delete();
    start_cyc_q.delete();
    rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!drv_start && n < 100);
    check("pwrup_latency", 32'(n), 32'd11);
    wait_idle("init_idle", 1000);
    check("init_len", 32'(log_q.size()), 32'd38);
    if (log_q.size() >= 38) begin
      check("init_0", 32'(log_q[0]), 32'h038);
      check("init_1", 32'(log_q[1]), 32'h00C);
      check("init_2", 32'(log_q[2]), 32'h001);
      check("init_3", 32'(log_q[3]), 32'h006);
      check("line1",  32'(log_q[4]), 32'h080);
      check("ch0",    32'(log_q[5]), 32'h120);
      check("line2",  32'(log_q[21]), 32'h0C0);
      check("ch31",   32'(log_q[37]), 32'h120);
      check("gap_plain", 32'(start_cyc_q[1] - start_cyc_q[0]), 32'd4);
      check("gap_clear", 32'(start_cyc_q[3] - start_cyc_q[2]), 32'd9);
    end
    check("init_done_hi", 32'(init_done), 32'd1);

    // Writes then refresh: 2nd transfer 'A', 34th 'Z'
    write_char(5'd0, 8'h41);
    write_char(5'd31, 8'h5A);
    log_q.delete();
    pulse_refresh();
    wait_idle("ref1_idle", 1000);
    check("ref1_len", 32'(log_q.size()), 32'd34);
    if (log_q.size() >= 34) begin
      check("ref1_2nd",  32'(log_q[1]), 32'h141);
      check("ref1_line2", 32'(log_q[17]), 32'h0C0);
      check("ref1_34th", 32'(log_q[33]), 32'h15A);
    end

    // Same-cycle write of the character being read, and merged pending refreshes
    log_q.delete();
    pulse_refresh();
    n = 0;
    while (log_q.size() < 3 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (drv_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("wait_done_timeout", 32'(n < 200), 32'd1);
    @(negedge clk);
    write_char(5'd2, 8'h33);
    pulse_refresh();
    repeat (7) @(negedge clk);
    pulse_refresh();
    repeat (11) @(negedge clk);
    pulse_refresh();
    wait_idle("merge_idle", 2000);
    check("merge_len", 32'(log_q.size()), 32'd68);
    if (log_q.size() >= 68) begin
      check("same_cycle_old", 32'(log_q[3]), 32'h120);
      check("next_new",       32'(log_q[37]), 32'h133);
    end

    // Withheld done: no new start, data stays put
    log_q.delete();
    hold = 1;
    pulse_refresh();
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (drv_start) n++;
    end
    check("hold_starts", 32'(n), 32'd1);
    check("hold_data", 32'({drv_cd, drv_data}), 32'h080);
    check("hold_busy", 32'(busy), 32'd1);
    hold = 0;
    wait_idle("hold_idle", 1000);
    check("hold_len", 32'(log_q.size()), 32'd34);

    // Spurious done in IDLE
    spur_cnt++;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (drv_start || busy !== 1'b0) n++;
    end
    check("spurious_done", 32'(n), 32'd0);

    // Reset during the 10th character
    write_char(5'd5, 8'h46);
    chars_in_seq = 0;
    pulse_refresh();
    n = 0;
    while (chars_in_seq < 10 && n < 500) begin @(negedge clk); n++; end
    check("tenth_char_reached", 32'(chars_in_seq), 32'd10);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("mid_rst_start", 32'(drv_start), 32'd0);
    check("mid_rst_cd",    32'(drv_cd),    32'd0);
    check("mid_rst_data",  32'(drv_data),  32'h00);
    check("mid_rst_init",  32'(init_done), 32'd0);
    check("mid_rst_busy",  32'(busy),      32'd1);
    repeat (3) @(negedge clk);
    log_q.delete();
    rst = 1'b1;
    wait_idle("reinit_idle", 1000);
    check("reinit_len", 32'(log_q.size()), 32'd38);
    if (log_q.size() >= 38) begin
      check("reinit_first", 32'(log_q[0]), 32'h038);
      check("reinit_ch0",   32'(log_q[5]), 32'h120);
      check("reinit_ch5",   32'(log_q[10]), 32'h120);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
